// File: rtl/io_scan_pkg.sv
// ---------------------------------------------------------------------------
// io_scan_pkg
//   Shared types and opcode encodings for the IO-tile scan chain controller.
//   Contents:
//     OPC_*          raw 2-bit opcode encodings as seen on cmd_op
//     scan_op_e      decoded command opcode
//     scan_state_e   controller FSM state
//     op_is_shift()  true for the opcodes that start with a chain shift
// ---------------------------------------------------------------------------
package io_scan_pkg;

    localparam logic [1:0] OPC_SHIFT         = 2'b00;
    localparam logic [1:0] OPC_CAPTURE       = 2'b01;
    localparam logic [1:0] OPC_SHIFT_CAPTURE = 2'b10;
    localparam logic [1:0] OPC_RSVD          = 2'b11;

    // The OP_ and ST_ prefixes keep the opcode and state enumerators apart,
    // since both sets contain a SHIFT and a CAPTURE member.
    typedef enum logic [1:0] {
        OP_SHIFT         = OPC_SHIFT,
        OP_CAPTURE       = OPC_CAPTURE,
        OP_SHIFT_CAPTURE = OPC_SHIFT_CAPTURE,
        OP_RSVD          = OPC_RSVD
    } scan_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } scan_state_e;

    function automatic logic op_is_shift(input scan_op_e op);
        return (op == OP_SHIFT) || (op == OP_SHIFT_CAPTURE);
    endfunction

endpackage

// File: rtl/io_scan_shreg.sv
// ---------------------------------------------------------------------------
// io_scan_shreg
//   CHAIN_LEN-bit shift register with parallel load, used to serialise the
//   command word towards the chain and to collect the word coming back.
//   Shifts towards bit 0: serial_in enters at the MSB.
//   Ports:
//     clk        clock
//     reset      synchronous, active-high; clears the register
//     load       parallel load of load_data (takes priority over shift)
//     load_data  word to load
//     shift      shift enable
//     serial_in  bit entering at the MSB on a shift
//     q          current register contents (q[0] is the next bit out)
//     shifted    value the register takes on a shift, for look-ahead use
// ---------------------------------------------------------------------------
module io_scan_shreg #(
    parameter int CHAIN_LEN = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CHAIN_LEN-1:0] load_data,
    input  logic                 shift,
    input  logic                 serial_in,
    output logic [CHAIN_LEN-1:0] q,
    output logic [CHAIN_LEN-1:0] shifted
);

    assign shifted = {serial_in, q[CHAIN_LEN-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= shifted;
        end
    end

endmodule

// File: rtl/io_scan_chain_ctrl.sv
// ---------------------------------------------------------------------------
// io_scan_chain_ctrl
//   Drives the IO-tile flip-flop scan chain: serialises a command word onto
//   scan_en/scan_si, collects scan_so into a response word, and issues single
//   functional-capture cycles on request.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     cmd_valid/cmd_ready   command handshake
//     cmd_op                00 SHIFT, 01 CAPTURE, 10 SHIFT_CAPTURE, 11 reserved
//     cmd_data              word to shift in, bit 0 first
//     rsp_valid/rsp_ready   response handshake
//     rsp_data              word shifted out, bit 0 = first bit seen on scan_so
//     rsp_err               reserved opcode, nothing was done to the chain
//     scan_en, scan_si      to SE and first SI of the IO FF chain
//     scan_so               from SO of the last IO FF
//     busy                  high whenever the controller is not idle
// ---------------------------------------------------------------------------
module io_scan_chain_ctrl
    import io_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CHAIN_LEN-1:0] cmd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 scan_en,
    output logic                 scan_si,
    input  logic                 scan_so,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    scan_state_e            state;
    scan_op_e               op_q;
    logic [CNT_W-1:0]       count;
    logic [CHAIN_LEN-1:0]   shreg_q;
    logic [CHAIN_LEN-1:0]   shreg_shifted;
    logic                   accept;
    logic                   rsp_accept;
    logic                   shift_en;
    logic                   last_shift;
    scan_op_e               cmd_op_e;

    assign cmd_op_e   = scan_op_e'(cmd_op);
    assign accept     = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign rsp_accept = (state == ST_RESP) && rsp_valid && rsp_ready;
    assign shift_en   = (state == ST_SHIFT);
    assign last_shift = (count == LAST_CNT);

    // The register loads the command word on accept and then swaps one bit
    // per shift cycle: the bit leaving at q[0] drives scan_si while scan_so
    // enters at the top, so after CHAIN_LEN shifts it holds the unloaded word.
    io_scan_shreg #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_shreg (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data (cmd_data),
        .shift     (shift_en),
        .serial_in (scan_so),
        .q         (shreg_q),
        .shifted   (shreg_shifted)
    );

    // Controller FSM. All outputs are registered, so scan_si is loaded one
    // edge ahead with the bit the shift register will present next
    // (cmd_data[0] on accept, shreg_shifted[0] while shifting).
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_SHIFT;
            count     <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            scan_en   <= 1'b0;
            scan_si   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        op_q      <= cmd_op_e;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        count     <= '0;
                        if (op_is_shift(cmd_op_e)) begin
                            state   <= ST_SHIFT;
                            scan_en <= 1'b1;
                            scan_si <= cmd_data[0];
                        end else if (cmd_op_e == OP_CAPTURE) begin
                            state <= ST_CAPTURE;
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end
                    end
                end

                ST_SHIFT: begin
                    count <= count + 1'b1;
                    if (last_shift) begin
                        scan_en <= 1'b0;
                        scan_si <= 1'b0;
                        if (op_q == OP_SHIFT_CAPTURE) begin
                            state <= ST_CAPTURE;
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= shreg_shifted;
                        end
                    end else begin
                        scan_si <= shreg_shifted[0];
                    end
                end

                // scan_en is already low here, so the chain takes its D inputs
                // on the edge that ends this cycle. For SHIFT_CAPTURE the
                // shift register still holds the pre-capture chain contents.
                ST_CAPTURE: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_data  <= (op_q == OP_SHIFT_CAPTURE) ? shreg_q : '0;
                end

                // Returning through IDLE with cmd_ready set guarantees one
                // idle cycle between a response accept and the next command.
                ST_RESP: begin
                    if (rsp_accept) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_scan_chain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_io_scan_chain_ctrl
//   Directed bench for io_scan_chain_ctrl with a behavioural 16-FF IO chain.
//   chain[0] is the FF nearest scan_so, so a word shifted in bit 0 first ends
//   up with bit 0 in chain[0] and the chain value reads as the same hex word.
// ---------------------------------------------------------------------------
module tb_io_scan_chain_ctrl;

    localparam int N = 16;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [N-1:0]  cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_data;
    logic          rsp_err;
    logic          scan_en;
    logic          scan_si;
    logic          scan_so;
    logic          busy;

    logic [N-1:0]  chain;
    logic [N-1:0]  chain_d;

    int assert_count;
    int fail_count;

    io_scan_chain_ctrl #(
        .CHAIN_LEN (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .scan_en   (scan_en),
        .scan_si   (scan_si),
        .scan_so   (scan_so),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural IO FF chain: shifts when SE is high, captures D otherwise.
    assign scan_so = chain[0];
    always @(posedge clk) begin
        if (scan_en === 1'b1) chain <= {scan_si, chain[N-1:1]};
        else                  chain <= chain_d;
    end

    // Offers one command, then follows it to the first rsp_valid cycle.
    // lat counts cycles after the accept cycle (-1 on timeout); en_cnt counts
    // cycles with scan_en high up to and including the response cycle.
    task automatic run_cmd(input logic [1:0] op, input logic [N-1:0] data,
                           input logic [N-1:0] d_run, output int lat,
                           output int en_cnt);
        int guard;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        chain_d   = d_run;
        lat       = 1;
        en_cnt    = 0;
        while (rsp_valid !== 1'b1 && lat < 64) begin
            if (scan_en === 1'b1) en_cnt++;
            @(negedge clk);
            lat++;
        end
        if (scan_en === 1'b1) en_cnt++;
        if (rsp_valid !== 1'b1) lat = -1;
    endtask

    task automatic consume_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        assert_count++;
        if ({cmd_ready, rsp_valid, rsp_err, scan_en, scan_si, busy} !== 6'b0) begin
            fail_count++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {cmd_ready, rsp_valid, rsp_err, scan_en, scan_si, busy});
        end
        assert_count++;
        if (rsp_data !== 16'h0000) begin
            fail_count++;
            $display("[TB] FAIL reset_rsp_data: got %h expected 0000", rsp_data);
        end
        reset = 1'b0;
        @(negedge clk);
        assert_count++;
        if (cmd_ready !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_shift();
        int lat, en_cnt;
        chain_d = 16'h1234;
        @(negedge clk);
        run_cmd(2'b00, 16'hA5C3, 16'hFFFF, lat, en_cnt);
        assert_count++;
        if (lat !== 17) begin
            fail_count++;
            $display("[TB] FAIL shift_latency: got %0d expected 17", lat);
        end
        assert_count++;
        if (en_cnt !== 16) begin
            fail_count++;
            $display("[TB] FAIL shift_scan_en_cycles: got %0d expected 16", en_cnt);
        end
        assert_count++;
        if (rsp_data !== 16'h1234 || rsp_err !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL shift_rsp: got %h err %b expected 1234 err 0", rsp_data, rsp_err);
        end
        assert_count++;
        if (chain !== 16'hA5C3) begin
            fail_count++;
            $display("[TB] FAIL shift_chain: got %h expected a5c3", chain);
        end
        consume_rsp();
        assert_count++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL shift_return_idle: got v%b b%b r%b expected v0 b0 r1",
                     rsp_valid, busy, cmd_ready);
        end
    endtask

    task automatic test_capture();
        int lat, en_cnt;
        chain_d = 16'hBEEF;
        @(negedge clk);
        run_cmd(2'b01, 16'hFFFF, 16'hBEEF, lat, en_cnt);
        assert_count++;
        if (lat !== 2) begin
            fail_count++;
            $display("[TB] FAIL capture_latency: got %0d expected 2", lat);
        end
        assert_count++;
        if (en_cnt !== 0) begin
            fail_count++;
            $display("[TB] FAIL capture_scan_en_cycles: got %0d expected 0", en_cnt);
        end
        assert_count++;
        if (rsp_data !== 16'h0000 || rsp_err !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL capture_rsp: got %h err %b expected 0000 err 0", rsp_data, rsp_err);
        end
        consume_rsp();
        run_cmd(2'b00, 16'h0000, 16'h0000, lat, en_cnt);
        assert_count++;
        if (rsp_data !== 16'hBEEF || lat !== 17) begin
            fail_count++;
            $display("[TB] FAIL capture_readback: got %h lat %0d expected beef lat 17", rsp_data, lat);
        end
        consume_rsp();
    endtask

    task automatic test_shift_capture();
        int lat, en_cnt;
        chain_d = 16'h3333;
        @(negedge clk);
        run_cmd(2'b10, 16'h00FF, 16'h5555, lat, en_cnt);
        assert_count++;
        if (lat !== 18) begin
            fail_count++;
            $display("[TB] FAIL shcap_latency: got %0d expected 18", lat);
        end
        assert_count++;
        if (en_cnt !== 16) begin
            fail_count++;
            $display("[TB] FAIL shcap_scan_en_cycles: got %0d expected 16", en_cnt);
        end
        assert_count++;
        if (rsp_data !== 16'h3333 || rsp_err !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL shcap_rsp: got %h err %b expected 3333 err 0", rsp_data, rsp_err);
        end
        assert_count++;
        if (chain !== 16'h5555) begin
            fail_count++;
            $display("[TB] FAIL shcap_chain: got %h expected 5555", chain);
        end
        consume_rsp();
        run_cmd(2'b00, 16'h0000, 16'h5555, lat, en_cnt);
        assert_count++;
        if (rsp_data !== 16'h5555) begin
            fail_count++;
            $display("[TB] FAIL shcap_readback: got %h expected 5555", rsp_data);
        end
        consume_rsp();
    endtask

    task automatic test_reserved();
        int lat, en_cnt;
        chain_d = 16'h0F0F;
        @(negedge clk);
        run_cmd(2'b11, 16'hFFFF, 16'h0F0F, lat, en_cnt);
        assert_count++;
        if (lat !== 1) begin
            fail_count++;
            $display("[TB] FAIL rsvd_latency: got %0d expected 1", lat);
        end
        assert_count++;
        if (en_cnt !== 0) begin
            fail_count++;
            $display("[TB] FAIL rsvd_scan_en_cycles: got %0d expected 0", en_cnt);
        end
        assert_count++;
        if (rsp_err !== 1'b1 || rsp_data !== 16'h0000) begin
            fail_count++;
            $display("[TB] FAIL rsvd_rsp: got %h err %b expected 0000 err 1", rsp_data, rsp_err);
        end
        consume_rsp();
    endtask

    task automatic test_back_to_back();
        int lat, en_cnt;
        chain_d = 16'h2222;
        @(negedge clk);
        run_cmd(2'b00, 16'h1111, 16'h0000, lat, en_cnt);
        assert_count++;
        if (rsp_data !== 16'h2222) begin
            fail_count++;
            $display("[TB] FAIL hold_rsp: got %h expected 2222", rsp_data);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            assert_count++;
            if ({rsp_valid, cmd_ready, busy} !== 3'b101 || rsp_data !== 16'h2222) begin
                fail_count++;
                $display("[TB] FAIL hold_cycle%0d: got v%b r%b b%b %h expected v1 r0 b1 2222",
                         i, rsp_valid, cmd_ready, busy, rsp_data);
            end
        end
        consume_rsp();
        assert_count++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL hold_release: got b%b v%b r%b expected b0 v0 r1",
                     busy, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat, en_cnt;
        chain_d = 16'h7777;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 16'hFFFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        assert_count++;
        if (scan_en !== 1'b1 || busy !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL midrst_shifting: got en%b b%b expected en1 b1", scan_en, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        assert_count++;
        if ({scan_en, busy, rsp_valid, cmd_ready} !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL midrst_state: got %b expected 0000",
                     {scan_en, busy, rsp_valid, cmd_ready});
        end
        reset   = 1'b0;
        chain_d = 16'h0F0F;
        @(negedge clk);
        run_cmd(2'b00, 16'hC3A5, 16'h0000, lat, en_cnt);
        assert_count++;
        if (lat !== 17 || en_cnt !== 16) begin
            fail_count++;
            $display("[TB] FAIL midrst_fresh_timing: got lat %0d en %0d expected 17 16", lat, en_cnt);
        end
        assert_count++;
        if (rsp_data !== 16'h0F0F || chain !== 16'hC3A5) begin
            fail_count++;
            $display("[TB] FAIL midrst_fresh_data: got %h chain %h expected 0f0f chain c3a5",
                     rsp_data, chain);
        end
        consume_rsp();
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_op       = 2'b00;
        cmd_data     = '0;
        rsp_ready    = 1'b0;
        chain_d      = '0;
        @(negedge clk);
        test_reset();
        test_shift();
        test_capture();
        test_shift_capture();
        test_reserved();
        test_back_to_back();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
